// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  // FETCH: may issue, WAIT: one request in flight,
  // DROP: in-flight response is stale, HOLD: word parked in the hold buffer
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Sequential successor address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register for a fetched instruction and its PC,
// used while IF/ID is stalled. Clear wins over load.
module if_hold_buf
  import if_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // Capture a word on load, invalidate on clear, otherwise keep contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// stall hold buffer, stale-response dropping after redirect, IF/ID register.
// Optional macro IF_MISALIGN_CHK_EN: a misaligned redirect target raises a
// sticky misalign_err and parks fetching; without it, the target's low two
// bits are forced to zero and misalign_err is tied low.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_write,
  input  logic            IFID_write,
  input  logic            flush_IF,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instruc_IFID,
  output logic [XLEN-1:0] PC_IFID,
  output logic [XLEN-1:0] PC_plus4_IFID,
  output logic            valid_IFID,
  output logic            misalign_err
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_req_pc_nxt;

  logic            w_imem_req;
  logic            w_word_avail;
  logic [XLEN-1:0] w_word_instr;
  logic [XLEN-1:0] w_word_pc;

  logic            w_hold_load;
  logic            w_hold_clear;
  logic            w_hold_valid;
  logic [XLEN-1:0] w_hold_instr;
  logic [XLEN-1:0] w_hold_pc;

  logic            w_bad_target;
  logic            w_park;
  logic [XLEN-1:0] w_redirect_pc;

  logic [XLEN-1:0] r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;
  logic [XLEN-1:0] r_ifid_pc4;
  logic            r_ifid_valid;

`ifdef IF_MISALIGN_CHK_EN
  logic r_misalign;

  assign w_bad_target  = redirect && (redirect_pc[1:0] != 2'b00);
  assign w_redirect_pc = redirect_pc;
  assign w_park        = r_misalign;

  // Sticky misaligned-target flag; once set, fetching stays parked until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_bad_target) begin
      r_misalign <= 1'b1;
    end else begin
      r_misalign <= r_misalign;
    end
  end

  assign misalign_err = r_misalign;
`else
  assign w_bad_target  = 1'b0;
  assign w_redirect_pc = redirect_pc & ~32'd3;
  assign w_park        = 1'b0;
  assign misalign_err  = 1'b0;
`endif

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_hold_valid),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc)
  );

  // Next-state, request and word-delivery decode; defaults keep everything idle.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_seq     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_imem_req   = 1'b0;
    w_word_avail = 1'b0;
    w_word_instr = NOP_INSTR;
    w_word_pc    = r_req_pc;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;

    case (r_state)
      FETCH: begin
        // A redirect blocks the request so a wrong-path fetch is never issued.
        w_imem_req = PC_write && !redirect && !w_park && !rst;
        if (w_imem_req && imem_ready) begin
          w_req_pc_nxt = r_pc;
          w_pc_seq     = pc_plus4(r_pc);
          w_state_nxt  = WAIT;
        end else begin
          w_state_nxt = FETCH;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          // Response closes the transaction, so even a coincident redirect
          // returns to FETCH rather than waiting for another response.
          if (redirect || flush_IF) begin
            w_state_nxt = FETCH;
          end else if (!IFID_write) begin
            w_hold_load = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_word_avail = 1'b1;
            w_word_instr = imem_rdata;
            w_word_pc    = r_req_pc;
            w_state_nxt  = FETCH;
          end
        end else if (redirect) begin
          w_state_nxt = DROP;
        end else begin
          w_state_nxt = WAIT;
        end
      end

      HOLD: begin
        if (redirect || flush_IF) begin
          w_hold_clear = 1'b1;
          w_state_nxt  = FETCH;
        end else if (IFID_write) begin
          w_word_avail = w_hold_valid;
          w_word_instr = w_hold_instr;
          w_word_pc    = w_hold_pc;
          w_hold_clear = 1'b1;
          w_state_nxt  = FETCH;
        end else begin
          w_state_nxt = HOLD;
        end
      end

      DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = DROP;
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // A (well-formed) redirect overrides sequential PC advance.
  assign w_pc_nxt = (redirect && !w_bad_target) ? w_redirect_pc : w_pc_seq;

  // FSM state, fetch PC and in-flight request address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
    end
  end

  // IF/ID register: flush > stall hold > new word > bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (flush_IF) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!IFID_write) begin
      r_ifid_valid <= r_ifid_valid;
    end else if (w_word_avail) begin
      r_ifid_instr <= w_word_instr;
      r_ifid_pc    <= w_word_pc;
      r_ifid_pc4   <= pc_plus4(w_word_pc);
      r_ifid_valid <= 1'b1;
    end else begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end
  end

  assign imem_req      = w_imem_req;
  assign imem_addr     = r_pc;
  assign Instruc_IFID  = r_ifid_instr;
  assign PC_IFID       = r_ifid_pc;
  assign PC_plus4_IFID = r_ifid_pc4;
  assign valid_IFID    = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: memory model with configurable
// latency, expected-instruction scoreboard, directed stall/flush/redirect cases.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, PC_write, IFID_write, flush_IF, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] Instruc_IFID, PC_IFID, PC_plus4_IFID;
  logic        valid_IFID, misalign_err;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PC_write      (PC_write),
    .IFID_write    (IFID_write),
    .flush_IF      (flush_IF),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .Instruc_IFID  (Instruc_IFID),
    .PC_IFID       (PC_IFID),
    .PC_plus4_IFID (PC_plus4_IFID),
    .valid_IFID    (valid_IFID),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          due;
    bit          dead;
  } pend_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] exp_pc;
  int          cyc;
  int          lat;
  int          loads;
  bit          last_hs;
  int          n_checks;
  int          n_fail;
  logic [31:0] a_saved;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h00B0_0193;
      default:       return {a[31:2], 2'b11} ^ 32'h1234_0000;
    endcase
  endfunction

  // One clock: sample pre-edge, update models, step, drive memory, score IF/ID.
  task automatic tick();
    bit    hs, resp, p_wr, p_fl, p_rst;
    pend_t it;
    exp_t  e;
    #1;
    hs    = imem_req && imem_ready;
    resp  = imem_rvalid;
    p_wr  = IFID_write;
    p_fl  = flush_IF;
    p_rst = rst;
    if (hs) check_eq("imem_addr", imem_addr, exp_pc);
    if (resp && pend.size() > 0) begin
      it = pend.pop_front();
      if (!(it.dead || redirect || p_fl)) exp_q.push_back('{word_at(it.pc), it.pc});
    end
    if (redirect) begin
      foreach (pend[i]) pend[i].dead = 1'b1;
`ifdef IF_MISALIGN_CHK_EN
      if (redirect_pc[1:0] == 2'b00) exp_pc = redirect_pc;
`else
      exp_pc = {redirect_pc[31:2], 2'b00};
`endif
    end
    if (hs) begin
      pend.push_back('{exp_pc, word_at(imem_addr), cyc + lat, 1'b0});
      exp_pc = exp_pc + 32'd4;
    end
    if (p_rst) begin
      pend.delete();
      exp_pc = 32'h0;
    end
    @(posedge clk);
    #1;
    cyc++;
    last_hs = hs;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].rdata;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (!p_rst && p_wr && !p_fl && valid_IFID) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_load", {31'd0, valid_IFID}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ifid_instr", Instruc_IFID, e.instr);
        check_eq("ifid_pc", PC_IFID, e.pc);
        check_eq("ifid_pc4", PC_plus4_IFID, e.pc + 32'd4);
        loads++;
      end
    end
  endtask

  task automatic run_until_loads(input int target, input string tag);
    for (int i = 0; i < 40 && loads < target; i++) tick();
    check_eq(tag, loads, target);
  endtask

  task automatic wait_rvalid(input string tag);
    for (int i = 0; i < 20 && !imem_rvalid; i++) tick();
    check_eq(tag, {31'd0, imem_rvalid}, 32'd1);
  endtask

  task automatic wait_hs(input string tag);
    last_hs = 1'b0;
    for (int i = 0; i < 20 && !last_hs; i++) tick();
    check_eq(tag, {31'd0, last_hs}, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; lat = 1; loads = 0; last_hs = 1'b0;
    exp_pc = 32'h0;
    rst = 1'b1; PC_write = 1'b1; IFID_write = 1'b1; flush_IF = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    #1;
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_instr", Instruc_IFID, NOP);
    check_eq("rst_pc", PC_IFID, 32'h0);
    check_eq("rst_pc4", PC_plus4_IFID, 32'h0);
    check_eq("rst_valid", {31'd0, valid_IFID}, 32'd0);
    check_eq("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0;

    // Basic fetch: first word two cycles after reset release
    tick();
    check_eq("lat_valid1", {31'd0, valid_IFID}, 32'd0);
    tick();
    check_eq("lat_valid2", {31'd0, valid_IFID}, 32'd1);
    check_eq("first_instr", Instruc_IFID, 32'h0050_0093);
    run_until_loads(2, "basic_loads");
    check_eq("second_pc4", PC_plus4_IFID, 32'h8);

    // Stall on response: word parks in HOLD, IF/ID unchanged
    wait_rvalid("hold_rvalid");
    IFID_write = 1'b0;
    tick();
    check_eq("hold_valid", {31'd0, valid_IFID}, 32'd0);
    check_eq("hold_instr", Instruc_IFID, NOP);
    tick();
    check_eq("hold_noreq", {31'd0, imem_req}, 32'd0);
    check_eq("hold_keep", Instruc_IFID, NOP);
    IFID_write = 1'b1;
    tick();
    check_eq("hold_rel_instr", Instruc_IFID, 32'h00B0_0193);
    check_eq("hold_rel_pc", PC_IFID, 32'h8);
    check_eq("hold_rel_loads", loads, 3);

    // Redirect during WAIT (2-cycle memory) -> response dropped
    lat = 2;
    wait_hs("redir_hs");
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    #1;
    check_eq("drop_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    check_eq("drop_valid", {31'd0, valid_IFID}, 32'd0);
    #1;
    check_eq("redir_req", {31'd0, imem_req}, 32'd1);
    check_eq("redir_addr", imem_addr, 32'h40);
    lat = 1;
    run_until_loads(5, "redir_loads");
    check_eq("redir_last_pc", PC_IFID, 32'h44);

    // Flush coincident with response
    wait_rvalid("flush_rvalid");
    a_saved = pend[0].pc + 32'd4;
    flush_IF = 1'b1;
    tick();
    flush_IF = 1'b0;
    check_eq("flush_instr", Instruc_IFID, NOP);
    check_eq("flush_pc", PC_IFID, 32'h0);
    check_eq("flush_pc4", PC_plus4_IFID, 32'h0);
    check_eq("flush_valid", {31'd0, valid_IFID}, 32'd0);
    #1;
    check_eq("flush_next_addr", imem_addr, a_saved);

    // Memory not ready for 3 cycles: request held stable
    imem_ready = 1'b0;
    #1;
    a_saved = imem_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_req", {31'd0, imem_req}, 32'd1);
      check_eq("stall_addr", imem_addr, a_saved);
    end
    imem_ready = 1'b1;
    run_until_loads(6, "stall_loads");

    // PC_write=0: no request, PC frozen
    PC_write = 1'b0;
    #1;
    a_saved = imem_addr;
    for (int i = 0; i < 3; i++) begin
      check_eq("pcw_req", {31'd0, imem_req}, 32'd0);
      tick();
      check_eq("pcw_addr", imem_addr, a_saved);
    end
    PC_write = 1'b1;

    // PC wrap at top of address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    run_until_loads(8, "wrap_loads");
    check_eq("wrap_pc", PC_IFID, 32'h0);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    check_eq("mis_err", {31'd0, misalign_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mis_noreq", {31'd0, imem_req}, 32'd0);
    end
    check_eq("mis_sticky", {31'd0, misalign_err}, 32'd1);
`else
    check_eq("mis_err_tied", {31'd0, misalign_err}, 32'd0);
    run_until_loads(9, "mis_loads");
    check_eq("mis_aligned_pc", PC_IFID, 32'h40);
`endif

    check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
